// File: rtl/cv32e40p_tb_obi_mem.sv
// Multi-port OBI memory model: round-robin arbitration onto one RAM, fixed response
// latency, optional LFSR grant stalls and memory-mapped end-of-test registers.
module cv32e40p_tb_obi_mem #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 20,
  parameter int unsigned RESP_LAT       = 1,
  parameter bit          STALL_EN       = 1'b0,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter logic [31:0] STATUS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] EXIT_ADDR      = 32'h2000_0004
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_PORTS-1:0]      req_i,
  output logic [NUM_PORTS-1:0]      gnt_o,
  input  logic [NUM_PORTS*32-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0]      we_i,
  input  logic [NUM_PORTS*4-1:0]    be_i,
  input  logic [NUM_PORTS*32-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]      rvalid_o,
  output logic [NUM_PORTS*32-1:0]   rdata_o,
  output logic                      tests_passed_o,
  output logic                      tests_failed_o,
  output logic                      exit_valid_o,
  output logic [31:0]               exit_value_o
);

  localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned RAM_WORDS = 2 ** (RAM_ADDR_WIDTH - 2);
  localparam logic [31:0] PASS_VALUE = 32'd123456789;

  if (NUM_PORTS == 0 || NUM_PORTS > 8) begin : g_bad_ports
    $fatal(1, "NUM_PORTS must be in 1..8");
  end
  if (RESP_LAT == 0 || RESP_LAT > 8) begin : g_bad_lat
    $fatal(1, "RESP_LAT must be in 1..8");
  end
  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $fatal(1, "LFSR_SEED must be non-zero");
  end

  genvar gi;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W:0]   cand;
  logic [PTR_W-1:0] win_idx;
  logic             win_valid;
  logic [15:0]      lfsr_reg;
  logic             lfsr_fb;
  logic             stall;
  logic             acc;

  logic [31:0]      acc_addr;
  logic             acc_we;
  logic [3:0]       acc_be;
  logic [31:0]      acc_wdata;
  logic             is_status;
  logic             is_exit;
  logic             is_periph;
  logic [RAM_ADDR_WIDTH-3:0] ram_idx;

  logic [31:0]      mem [RAM_WORDS];
  logic [31:0]      ram_rdata_reg;
  logic             acc_valid_reg;
  logic [PTR_W-1:0] acc_port_reg;
  logic             acc_rd_ram_reg;

  logic             tests_passed_reg;
  logic             tests_failed_reg;
  logic             exit_valid_reg;
  logic [31:0]      exit_value_reg;

  // Round-robin search starting at the pointer, wrapping at NUM_PORTS.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, ptr_reg} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
        cand = cand - (PTR_W+1)'(NUM_PORTS);
      end
      if (!win_valid && req_i[cand[PTR_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign lfsr_fb  = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign stall    = STALL_EN && (lfsr_reg[1:0] == 2'b00);
  assign acc      = win_valid && !stall;
  assign ptr_next = (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + PTR_W'(1);

  always_comb begin
    gnt_o = '0;
    if (acc) begin
      gnt_o = NUM_PORTS'(1) << win_idx;
    end
  end

  assign acc_addr  = addr_i[{win_idx, 5'b00000} +: 32];
  assign acc_wdata = wdata_i[{win_idx, 5'b00000} +: 32];
  assign acc_be    = be_i[{win_idx, 2'b00} +: 4];
  assign acc_we    = we_i[win_idx];
  assign is_status = (acc_addr == STATUS_ADDR);
  assign is_exit   = (acc_addr == EXIT_ADDR);
  assign is_periph = is_status || is_exit;
  assign ram_idx   = acc_addr[RAM_ADDR_WIDTH-1:2];

  // RAM keeps its contents across reset; read data is captured at the accept edge.
  always_ff @(posedge clk_i) begin
    if (acc && !is_periph) begin
      if (acc_we) begin
        for (int b = 0; b < 4; b++) begin
          if (acc_be[b]) begin
            mem[ram_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
          end
        end
      end else begin
        ram_rdata_reg <= mem[ram_idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_reg          <= '0;
      lfsr_reg         <= LFSR_SEED;
      acc_valid_reg    <= 1'b0;
      acc_port_reg     <= '0;
      acc_rd_ram_reg   <= 1'b0;
      tests_passed_reg <= 1'b0;
      tests_failed_reg <= 1'b0;
      exit_valid_reg   <= 1'b0;
      exit_value_reg   <= '0;
    end else begin
      lfsr_reg       <= {lfsr_reg[14:0], lfsr_fb};
      acc_valid_reg  <= acc;
      acc_port_reg   <= win_idx;
      acc_rd_ram_reg <= acc && !acc_we && !is_periph;
      if (acc) begin
        ptr_reg <= ptr_next;
      end
      if (acc && acc_we && is_status) begin
        if (acc_wdata == PASS_VALUE) begin
          tests_passed_reg <= 1'b1;
        end else begin
          tests_failed_reg <= 1'b1;
        end
      end
      if (acc && acc_we && is_exit) begin
        exit_valid_reg <= 1'b1;
        exit_value_reg <= acc_wdata;
      end
    end
  end

  assign tests_passed_o = tests_passed_reg;
  assign tests_failed_o = tests_failed_reg;
  assign exit_valid_o   = exit_valid_reg;
  assign exit_value_o   = exit_value_reg;

  // Stage 0 of every response pipe is the registered accept; deeper stages shift it.
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic        s0_valid;
    logic [31:0] s0_data;
    logic        out_valid;
    logic [31:0] out_data;

    assign s0_valid = acc_valid_reg && (acc_port_reg == PTR_W'(gi));
    assign s0_data  = acc_rd_ram_reg ? ram_rdata_reg : 32'h0;

    if (RESP_LAT == 1) begin : g_direct
      assign out_valid = s0_valid;
      assign out_data  = s0_data;
    end else begin : g_pipe
      logic [RESP_LAT-1:1] v_reg;
      logic [31:0]         d_reg [RESP_LAT-1:1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          v_reg <= '0;
          for (int i = 1; i < RESP_LAT; i++) begin
            d_reg[i] <= '0;
          end
        end else begin
          v_reg[1] <= s0_valid;
          d_reg[1] <= s0_data;
          for (int i = 2; i < RESP_LAT; i++) begin
            v_reg[i] <= v_reg[i-1];
            d_reg[i] <= d_reg[i-1];
          end
        end
      end

      assign out_valid = v_reg[RESP_LAT-1];
      assign out_data  = d_reg[RESP_LAT-1];
    end

    assign rvalid_o[gi]          = out_valid;
    assign rdata_o[32*gi +: 32]  = out_valid ? out_data : 32'h0;
  end

`ifndef SYNTHESIS
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_hold_chk
    assert property (@(posedge clk_i) disable iff (rst_i)
      (req_i[gi] && !gnt_o[gi]) |=>
        $stable({addr_i[32*gi +: 32], we_i[gi], be_i[4*gi +: 4], wdata_i[32*gi +: 32]}))
      else $error("port %0d changed its request while waiting for grant", gi);
  end
`endif

endmodule

// File: tb/tb_cv32e40p_tb_obi_mem.sv
// Bench for cv32e40p_tb_obi_mem: three instances (latency 1, latency 4, latency 2 with
// grant stalls) driven by directed vectors; a negedge monitor checks against a scoreboard.
`timescale 1ns/1ps
module tb_cv32e40p_tb_obi_mem;

  localparam int NI = 3;
  localparam logic [31:0] STATUS = 32'h2000_0000;
  localparam logic [31:0] EXITR  = 32'h2000_0004;

  logic        clk = 1'b0;
  logic        rst        [NI];
  logic [1:0]  req        [NI];
  logic [1:0]  gnt        [NI];
  logic [63:0] addr       [NI];
  logic [1:0]  we         [NI];
  logic [7:0]  be         [NI];
  logic [63:0] wdata      [NI];
  logic [1:0]  rvalid     [NI];
  logic [63:0] rdata      [NI];
  logic        passed     [NI];
  logic        failed     [NI];
  logic        exit_valid [NI];
  logic [31:0] exit_value [NI];

  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  int rv_count [NI];
  logic [31:0] exp_data_q [2*NI][$];
  int          exp_due_q  [2*NI][$];
  int          gnt_log_port [$];
  int          gnt_log_cyc  [$];
  bit          log_en = 1'b0;
  bit          stop6 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  for (gi = 0; gi < NI; gi++) begin : g_dut
    cv32e40p_tb_obi_mem #(
      .NUM_PORTS      (2),
      .RAM_ADDR_WIDTH (12),
      .RESP_LAT       ((gi == 1) ? 4 : (gi == 2) ? 2 : 1),
      .STALL_EN       ((gi == 2) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst[gi]),
      .req_i          (req[gi]),
      .gnt_o          (gnt[gi]),
      .addr_i         (addr[gi]),
      .we_i           (we[gi]),
      .be_i           (be[gi]),
      .wdata_i        (wdata[gi]),
      .rvalid_o       (rvalid[gi]),
      .rdata_o        (rdata[gi]),
      .tests_passed_o (passed[gi]),
      .tests_failed_o (failed[gi]),
      .exit_valid_o   (exit_valid[gi]),
      .exit_value_o   (exit_value[gi])
    );
  end

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents one request and holds it until granted; the expected response is queued on accept.
  task automatic issue(input int k, input int p, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp);
    int waited;
    waited = 0;
    @(negedge clk);
    req[k][p]            = 1'b1;
    we[k][p]             = w;
    addr[k][32*p +: 32]  = a;
    be[k][4*p +: 4]      = b;
    wdata[k][32*p +: 32] = d;
    #1;
    while (!gnt[k][p] && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (gnt[k][p]) begin
      exp_data_q[2*k+p].push_back(exp);
      exp_due_q[2*k+p].push_back(cyc + lat_of(k));
      if (log_en && k == 0) begin
        gnt_log_port.push_back(p);
        gnt_log_cyc.push_back(cyc);
      end
    end else begin
      nchk++;
      nerr++;
      $display("FAIL grant_timeout inst%0d port%0d: no grant after %0d cycles, required within 100", k, p, waited);
      req[k][p] = 1'b0;
    end
  endtask

  task automatic idle(input int k, input int p);
    @(negedge clk);
    req[k][p] = 1'b0;
  endtask

  logic [31:0] mon_d;
  int          mon_due;
  int          qi;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      nchk++;
      if (!$onehot0(gnt[k])) begin
        nerr++;
        $display("FAIL gnt_onehot inst%0d: got %b, expected at most one bit set", k, gnt[k]);
      end
      for (int p = 0; p < 2; p++) begin
        qi = 2*k + p;
        if (rvalid[k][p]) begin
          rv_count[k]++;
          $display("resp inst=%0d port=%0d cyc=%0d rdata=%h", k, p, cyc, rdata[k][32*p +: 32]);
          if (exp_data_q[qi].size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL resp_unexpected inst%0d port%0d: got rvalid at cycle %0d, expected none", k, p, cyc);
          end else begin
            mon_d   = exp_data_q[qi].pop_front();
            mon_due = exp_due_q[qi].pop_front();
            chk($sformatf("resp_data inst%0d port%0d", k, p), rdata[k][32*p +: 32], mon_d);
            chk($sformatf("resp_cycle inst%0d port%0d", k, p), 32'(cyc), 32'(mon_due));
          end
        end else if (exp_due_q[qi].size() != 0 && exp_due_q[qi][0] < cyc) begin
          nchk++;
          nerr++;
          $display("FAIL resp_missing inst%0d port%0d: no rvalid by cycle %0d, required at cycle %0d",
                   k, p, cyc, exp_due_q[qi][0]);
          mon_d   = exp_data_q[qi].pop_front();
          mon_due = exp_due_q[qi].pop_front();
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion before 400us");
    $fatal(1, "watchdog expired");
  end

  int rv_before;
  int both;
  int nogrant;
  int i0;
  int i1;

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req[k] = '0; we[k] = '0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset_gnt%0d", k),        32'(gnt[k]), 32'h0);
      chk($sformatf("reset_rvalid%0d", k),     32'(rvalid[k]), 32'h0);
      chk($sformatf("reset_rdata%0d", k),      rdata[k][31:0] | rdata[k][63:32], 32'h0);
      chk($sformatf("reset_passed%0d", k),     32'(passed[k]), 32'h0);
      chk($sformatf("reset_failed%0d", k),     32'(failed[k]), 32'h0);
      chk($sformatf("reset_exit_valid%0d", k), 32'(exit_valid[k]), 32'h0);
      chk($sformatf("reset_exit_value%0d", k), exit_value[k], 32'h0);
    end

    // Write then read-after-write, single-cycle latency.
    issue(0, 0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0);
    issue(0, 0, 1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF);
    idle(0, 0);

    // Partial byte-lane write.
    issue(0, 0, 1'b1, 32'h40, 4'hF, 32'h11223344, 32'h0);
    issue(0, 0, 1'b1, 32'h40, 4'b0010, 32'h0000AB00, 32'h0);
    issue(0, 0, 1'b0, 32'h40, 4'hF, 32'h0, 32'h1122AB44);
    idle(0, 0);

    // Status and exit registers; STATUS aliases RAM word 0 in the low address bits.
    issue(0, 0, 1'b1, 32'h0, 4'hF, 32'hCAFE0001, 32'h0);
    issue(0, 0, 1'b1, STATUS, 4'hF, 32'd123456789, 32'h0);
    chk("passed_same_cycle", 32'(passed[0]), 32'h0);
    issue(0, 0, 1'b1, EXITR, 4'hF, 32'h5, 32'h0);
    chk("passed_next_cycle", 32'(passed[0]), 32'h1);
    chk("exit_valid_same_cycle", 32'(exit_valid[0]), 32'h0);
    idle(0, 0);
    chk("exit_valid_set", 32'(exit_valid[0]), 32'h1);
    chk("exit_value_5", exit_value[0], 32'h5);
    chk("failed_clear", 32'(failed[0]), 32'h0);
    issue(0, 0, 1'b0, 32'h0, 4'hF, 32'h0, 32'hCAFE0001);
    issue(0, 0, 1'b0, STATUS, 4'hF, 32'h0, 32'h0);
    idle(0, 0);
    issue(0, 1, 1'b1, STATUS, 4'hF, 32'h7, 32'h0);
    issue(0, 1, 1'b1, EXITR, 4'h1, 32'h0000_0109, 32'h0);
    idle(0, 1);
    chk("failed_set", 32'(failed[0]), 32'h1);
    chk("passed_sticky", 32'(passed[0]), 32'h1);
    chk("exit_value_overwrite", exit_value[0], 32'h0000_0109);

    // Both ports contend; the last grant went to port 1, so port 0 wins first.
    log_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 0, 1'b1, 32'h200 + 32'(4*i), 4'hF, 32'hA0 + 32'(i), 32'h0);
        idle(0, 0);
      end
      begin
        for (int i = 0; i < 4; i++) issue(0, 1, 1'b1, 32'h300 + 32'(4*i), 4'hF, 32'hB0 + 32'(i), 32'h0);
        idle(0, 1);
      end
    join
    log_en = 1'b0;
    chk("rr_log_len", 32'(gnt_log_port.size()), 32'd8);
    for (int i = 0; i < 8 && i < gnt_log_port.size(); i++) begin
      chk($sformatf("rr_order%0d", i), 32'(gnt_log_port[i]), 32'(i % 2));
    end
    if (gnt_log_cyc.size() == 8) begin
      chk("rr_span", 32'(gnt_log_cyc[7] - gnt_log_cyc[0]), 32'd7);
    end
    issue(0, 1, 1'b0, 32'h204, 4'hF, 32'h0, 32'hA1);
    idle(0, 1);
    issue(0, 0, 1'b0, 32'h30C, 4'hF, 32'h0, 32'hB3);
    idle(0, 0);

    // Latency 4: preload, then four back-to-back reads on port 1.
    for (int i = 0; i < 4; i++) issue(1, 0, 1'b1, 32'(4*i), 4'hF, 32'(i + 1), 32'h0);
    idle(1, 0);
    for (int i = 0; i < 4; i++) issue(1, 1, 1'b0, 32'(4*i), 4'hF, 32'h0, 32'(i + 1));
    idle(1, 1);
    repeat (6) @(negedge clk);

    // Reset with three reads in flight: none of them may come back.
    for (int i = 0; i < 3; i++) issue(1, 0, 1'b0, 32'(4*i), 4'hF, 32'h0, 32'(i + 1));
    @(negedge clk);
    rst[1] = 1'b1;
    req[1] = '0;
    exp_data_q[2].delete(); exp_due_q[2].delete();
    exp_data_q[3].delete(); exp_due_q[3].delete();
    rv_before = rv_count[1];
    repeat (3) @(negedge clk);
    chk("rvalid_in_reset", 32'(rvalid[1]), 32'h0);
    rst[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_rvalid_after_reset", 32'(rv_count[1] - rv_before), 32'h0);
    issue(1, 0, 1'b0, 32'h4, 4'hF, 32'h0, 32'h2);
    idle(1, 0);

    // Stalled instance under continuous contention.
    both = 0; nogrant = 0; i0 = 0; i1 = 0;
    fork
      begin
        while (!stop6) begin
          issue(2, 0, 1'b1, 32'h800 + 32'(4*(i0 % 16)), 4'hF, 32'(i0), 32'h0);
          i0++;
        end
        idle(2, 0);
      end
      begin
        while (!stop6) begin
          issue(2, 1, 1'b1, 32'h900 + 32'(4*(i1 % 16)), 4'hF, 32'(i1), 32'h0);
          i1++;
        end
        idle(2, 1);
      end
      begin
        repeat (1000) begin
          @(negedge clk);
          #2;
          if (req[2] == 2'b11) begin
            both++;
            if (gnt[2] == 2'b00) nogrant++;
          end
        end
        stop6 = 1'b1;
      end
    join
    nchk++;
    if (both < 900 || nogrant * 100 < both * 15 || nogrant * 100 > both * 35) begin
      nerr++;
      $display("FAIL stall_rate: got %0d of %0d contended cycles without grant, expected 15..35 percent over >=900 cycles",
               nogrant, both);
    end

    repeat (12) @(negedge clk);
    for (int q = 0; q < 2*NI; q++) begin
      chk($sformatf("sb_drain q%0d", q), 32'(exp_data_q[q].size()), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
